// File: rtl/mux_scan_ctrl.sv
// Channel scan sequencer for a downstream 4:1 mux: dwells DWELL cycles per enabled
// channel, samples o_in, and records each sample in a per-channel capture bank.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for an accepted start; s holds its last value
// ST_DWELL | s settling on a channel; sample taken when cnt reaches DWELL-1
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [3:0] mask,
  input  logic [1:0] o_in,
  output logic [1:0] s,
  output logic       busy,
  output logic       sample_valid,
  output logic [1:0] sample_ch,
  output logic [1:0] sample_data,
  output logic [7:0] cap,
  output logic       done
);

  typedef enum logic {ST_IDLE, ST_DWELL} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] mask_q, mask_nx;
  logic       mode_q, mode_nx;
  logic [1:0] s_nx, sample_ch_nx, sample_data_nx, nxt_ch;
  logic [7:0] cap_nx;
  logic       busy_nx, sample_valid_nx, done_nx;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    logic [1:0] ch;
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) ch = 2'(i);
    end
    return ch;
  endfunction

  // Searches cur+1, cur+2, cur+3 then cur itself; descending loop lets the nearest win.
  function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] nxt;
    logic [1:0] idx;
    nxt = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) nxt = idx;
    end
    return nxt;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      mask_q       <= 4'd0;
      mode_q       <= 1'b0;
      s            <= 2'd0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      sample_data  <= 2'd0;
      cap          <= 8'h00;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      mask_q       <= mask_nx;
      mode_q       <= mode_nx;
      s            <= s_nx;
      busy         <= busy_nx;
      sample_valid <= sample_valid_nx;
      sample_ch    <= sample_ch_nx;
      sample_data  <= sample_data_nx;
      cap          <= cap_nx;
      done         <= done_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    mask_nx         = mask_q;
    mode_nx         = mode_q;
    s_nx            = s;
    sample_valid_nx = 1'b0;
    sample_ch_nx    = sample_ch;
    sample_data_nx  = sample_data;
    cap_nx          = cap;
    done_nx         = 1'b0;
    nxt_ch          = next_ch(mask_q, s);

    case (state)
      ST_IDLE: begin
        if (start && !stop && (mask != 4'd0)) begin
          mask_nx  = mask;
          mode_nx  = mode;
          s_nx     = lowest_ch(mask);
          cnt_nx   = 8'd0;
          state_nx = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          state_nx = ST_IDLE;
          cnt_nx   = 8'd0;
        end else if (cnt != CNT_LAST) begin
          cnt_nx = cnt + 8'd1;
        end else begin
          sample_valid_nx           = 1'b1;
          sample_ch_nx              = s;
          sample_data_nx            = o_in;
          cap_nx[{s, 1'b0} +: 2]    = o_in;
          s_nx                      = nxt_ch;
          cnt_nx                    = 8'd0;
          // Wrap (next <= current) closes a sweep; single-sweep mode stops here.
          if ((nxt_ch <= s) && !mode_q) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    busy_nx = (state_nx == ST_DWELL);
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scenarios plus randomized scans, each checked
// against a schedule-based model (sample edges at multiples of DWELL after start).
module tb_mux_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [3:0] mask = 4'd0;
  logic [1:0] o_in;
  logic [1:0] s, sample_ch, sample_data;
  logic       busy, sample_valid, done;
  logic [7:0] cap;

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0] m_cap [4];
  logic [1:0] m_ch, m_data, m_s;

  mux_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .o_in(o_in), .s(s), .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch),
    .sample_data(sample_data), .cap(cap), .done(done)
  );

  // Mux model: channel n carries the constant n.
  assign o_in = s;

  always #5 clk = ~clk;

  function automatic logic [7:0] m_cap_packed();
    return {m_cap[3], m_cap[2], m_cap[1], m_cap[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cap[i] = 2'd0;
    m_ch = 2'd0; m_data = 2'd0; m_s = 2'd0;
  endtask

  // Start a scan at edge 0 and check every output for n_cyc following edges.
  // stop_edge = 0 means no stop; otherwise stop is high just before that edge.
  task automatic run_scan(input logic [3:0] m, input logic md, input int stop_edge,
                          input int n_cyc, input string name);
    int ch_list[$];
    int len, natural_end, end_edge, tp, j, ch;
    bit stopped, is_sample, exp_done, exp_busy;
    for (int c = 0; c < 4; c++) if (m[c]) ch_list.push_back(c);
    len = ch_list.size();
    natural_end = md ? 1000000 : DWELL * len;
    stopped = (stop_edge != 0) && (stop_edge <= natural_end);
    end_edge = stopped ? stop_edge : natural_end;

    @(negedge clk); start = 1'b1; mask = m; mode = md; stop = 1'b0;
    @(posedge clk); #1;
    m_s = 2'(ch_list[0]);
    n_checks++;
    if (busy !== 1'b1 || s !== m_s || sample_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b s=%0d sv=%b, want busy=1 s=%0d sv=0", name, busy, s, sample_valid, m_s);
    end

    for (int t = 1; t <= n_cyc; t++) begin
      @(negedge clk);
      if (t <= end_edge) begin
        start = 1'($urandom); mask = 4'($urandom); mode = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      stop = (t == stop_edge);
      @(posedge clk); #1;
      j = t / DWELL;
      is_sample = (t % DWELL == 0) && (t <= end_edge) && !(stopped && t == stop_edge);
      exp_done = is_sample && !md && (j == len);
      exp_busy = (t < end_edge);
      if (is_sample) begin
        ch = ch_list[(j - 1) % len];
        m_ch = 2'(ch); m_data = 2'(ch); m_cap[ch] = 2'(ch);
      end
      tp = (t < end_edge) ? t : (stopped ? end_edge - 1 : end_edge);
      m_s = 2'(ch_list[(tp / DWELL) % len]);

      n_checks++;
      if (sample_valid !== is_sample) begin
        n_fail++; $display("FAIL %s sample_valid t=%0d: got %b want %b", name, t, sample_valid, is_sample);
      end
      n_checks++;
      if (done !== exp_done) begin
        n_fail++; $display("FAIL %s done t=%0d: got %b want %b", name, t, done, exp_done);
      end
      n_checks++;
      if (busy !== exp_busy) begin
        n_fail++; $display("FAIL %s busy t=%0d: got %b want %b", name, t, busy, exp_busy);
      end
      n_checks++;
      if (s !== m_s) begin
        n_fail++; $display("FAIL %s s t=%0d: got %0d want %0d", name, t, s, m_s);
      end
      n_checks++;
      if (sample_ch !== m_ch || sample_data !== m_data) begin
        n_fail++;
        $display("FAIL %s sample t=%0d: got ch=%0d data=%0d want ch=%0d data=%0d", name, t, sample_ch, sample_data, m_ch, m_data);
      end
      n_checks++;
      if (cap !== m_cap_packed()) begin
        n_fail++; $display("FAIL %s cap t=%0d: got %b want %b", name, t, cap, m_cap_packed());
      end
    end
    @(negedge clk); start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    model_reset();
    n_checks++;
    if ({s, busy, sample_valid, sample_ch, sample_data, cap, done} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset: s=%0d busy=%b sv=%b ch=%0d data=%0d cap=%h done=%b, want all 0",
               s, busy, sample_valid, sample_ch, sample_data, cap, done);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release busy: got %b want 0", busy);
    end
  endtask

  task automatic test_full_sweep();
    run_scan(4'b1111, 1'b0, 0, 20, "full_sweep");
    n_checks++;
    if (cap !== 8'b11100100) begin
      n_fail++; $display("FAIL full_sweep cap: got %b want 11100100", cap);
    end
  endtask

  task automatic test_sparse();
    run_scan(4'b0101, 1'b0, 0, 12, "sparse");
  endtask

  task automatic test_continuous();
    run_scan(4'b1000, 1'b1, 13, 18, "continuous");
  endtask

  task automatic test_abort_null();
    run_scan(4'b1111, 1'b0, 8, 12, "abort");
    @(negedge clk); start = 1'b1; mask = 4'b0000; mode = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || s !== m_s) begin
      n_fail++; $display("FAIL null_start: busy=%b s=%0d want busy=0 s=%0d", busy, s, m_s);
    end
    @(negedge clk); start = 1'b1; stop = 1'b1; mask = 4'b1111;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || s !== m_s) begin
      n_fail++; $display("FAIL start_with_stop: busy=%b s=%0d want busy=0 s=%0d", busy, s, m_s);
    end
    @(negedge clk); start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] m;
    logic md;
    int len, se, ncyc;
    for (int it = 0; it < 12; it++) begin
      m = 4'($urandom_range(1, 15));
      md = 1'($urandom);
      len = $countones(m);
      if (md) begin
        se = $urandom_range(1, 30);
        ncyc = se + 3;
      end else begin
        se = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DWELL * len + 2) : 0;
        ncyc = DWELL * 4 + 3;
      end
      run_scan(m, md, se, ncyc, "random");
    end
  endtask

  task automatic test_reset_mid();
    run_scan(4'b1111, 1'b0, 0, 10, "pre_reset");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({s, busy, sample_valid, sample_ch, sample_data, cap, done} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_mid async: s=%0d busy=%b sv=%b ch=%0d data=%0d cap=%h done=%b, want all 0",
               s, busy, sample_valid, sample_ch, sample_data, cap, done);
    end
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({s, busy, sample_valid, cap, done} !== 13'd0) begin
      n_fail++; $display("FAIL reset_mid held: s=%0d busy=%b sv=%b cap=%h done=%b, want 0", s, busy, sample_valid, cap, done);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(posedge clk); #1;
      n_checks++;
      if (sample_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid after release t=%0d: sv=%b done=%b busy=%b want 0", t, sample_valid, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_sparse();
    test_continuous();
    test_abort_null();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 4 (legal range 2..255): number of clock cycles `s` is held on each channel before sampling.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 start  input  1  request to begin a scan; honoured only in IDLE.
REQ-005 stop  input  1  abort request; honoured in any non-IDLE state.
REQ-006 mode  input  1  scan mode: 0 = single sweep, 1 = continuous; latched at an accepted start.
REQ-007 mask  input  4  channel enable, bit n enables channel n; latched at an accepted start.
REQ-008 o_in  input  2  data returned by the downstream 4:1 mux for the channel currently on `s`.
REQ-009 s  output  2  channel select driven to the mux select input.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 sample_valid  output  1  one-cycle strobe marking a new sample on sample_ch/sample_data.
REQ-012 sample_ch  output  2  channel of the most recent sample.
REQ-013 sample_data  output  2  value of the most recent sample.
REQ-014 cap  output  8  capture bank; cap[2n+1:2n] holds the last sample taken from channel n.
REQ-015 done  output  1  one-cycle strobe at the end of a completed single sweep.

Function
REQ-016 The FSM SHALL have two states, IDLE and DWELL, plus a dwell counter `cnt` that is 8 bits wide.
REQ-017 Start acceptance, IDLE only: start=1, stop=0 and mask!=0 SHALL give one edge that:
- latches mask and mode;
- drives `s` to the lowest enabled channel;
- clears `cnt` to 0;
- enters DWELL.
REQ-018 IDLE otherwise SHALL stay in IDLE, covering start with mask==0, start and stop in the same cycle, and no start; `s` holds its last value.
REQ-019 DWELL, stop=0, cnt<DWELL-1: `cnt` SHALL increment and `s` SHALL hold.
REQ-020 DWELL, stop=0, cnt==DWELL-1 (the sample edge): o_in SHALL be captured on that edge into sample_data and into the `cap` slot for channel `s`, sample_ch SHALL take `s`, and sample_valid SHALL be high for exactly the following cycle.
REQ-021 Next channel: on the sample edge `s` SHALL advance to the next enabled channel in ascending order, wrapping 3->0.
REQ-022 End of sweep: a sweep ends when the next enabled channel is less than or equal to the current one (wrap).
REQ-023 At end of sweep with mode=0, the FSM SHALL go to IDLE and done SHALL pulse for one cycle, coincident with the last sample_valid.
REQ-024 At end of sweep with mode=1, scanning SHALL continue with `cnt` cleared to 0 and no done pulse.
REQ-025 With a single enabled channel, `s` SHALL stay constant; mode 1 produces one sample every DWELL cycles.
REQ-026 stop=1 in DWELL SHALL return the FSM to IDLE at the next edge, including on a would-be sample edge.
REQ-027 On stop: no sample is taken, no sample_valid, no done, `cap` unchanged, and `s` holds.
REQ-028 start while busy SHALL be ignored; changes to mask and mode while busy SHALL have no effect.
REQ-029 Latency: an accepted start at edge k SHALL produce the first sample edge at edge k+DWELL; consecutive samples are DWELL cycles apart.
REQ-030 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force:
- state IDLE, cnt=0;
- s=2'b00, busy=0, sample_valid=0, done=0;
- sample_ch=0, sample_data=0, cap=8'h00;
- latched mask=0 and latched mode=0.
REQ-032 Reset asserted mid-scan SHALL abandon the scan with no pending strobe emitted after release; the first edge after release behaves as IDLE.

Verification
REQ-033 The bench SHALL use DWELL=4 and model the mux with o_in = channel data i0..i3 = 00, 01, 10, 11 selected by `s`.
REQ-034 Single full sweep: mask=1111, mode=0, start at edge k -> samples at edges k+4, k+8, k+12, k+16 on ch 0,1,2,3 with data 00,01,10,11; cap=8'b11100100; done with the last sample; busy=0 afterwards.
REQ-035 Sparse mask: mask=0101, mode=0 -> s sequence 0,2; two samples (ch0=00, ch2=10); done at k+8; cap[3:2] and cap[7:6] unchanged.
REQ-036 Continuous single channel: mask=1000, mode=1 -> s=3 constant; sample ch3=11 every 4 cycles; stop after the 3rd sample -> IDLE, no done.
REQ-037 Abort and null start: stop at cnt==3 on ch1 -> no ch1 sample, cap unchanged, busy=0; start with mask=0000 -> busy stays 0.
REQ-038 Reset mid-scan: rst_n low during DWELL on ch2 -> all outputs read the REQ-031 values while low; no strobe after release.
